// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default parameters for debounce_sync
package debounce_pkg;

    // Debounce FSM states: two stable idles and two qualifying waits
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF  = 2;
    localparam int CNT_WIDTH_DEF    = 4;
    localparam int STABLE_COUNT_DEF = 10;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// rtl/debounce_sync_sync_chain.sv - parameterized reset-to-zero flip-flop synchronizer chain
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] stage_q;

    // Shift the raw input through the chain; only stage 0 ever sees the asynchronous input
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus debounce FSM with rise/fall strobes
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int STABLE_COUNT = STABLE_COUNT_DEF
) (
    input  logic Clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync_out;
    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 q_q;
    logic                 rise_q;
    logic                 fall_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk (Clk),
        .rst (rst),
        .d_i (din),
        .q_o (sync_out)
    );

    // Qualify a level change by counting consecutive agreeing samples; strobes last one cycle
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_out) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_out) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        q_q     <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_out) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync_out) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        q_q     <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - scoreboard bench for debounce_sync against a run-length reference model
module tb_debounce_sync;

    localparam int SS = 2;
    localparam int SC = 10;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic Clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic q, rise, fall, busy;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    time  first_rise = 0;

    logic m_q;
    int   m_run;
    logic pipe[$];

    debounce_sync dut (
        .Clk  (Clk),
        .rst  (rst),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
        end
    endtask

    // Reference: the FSM sees din delayed by SS edges; q flips after SC consecutive samples differing from it
    task automatic model_reset();
        m_q   = 1'b0;
        m_run = 0;
        pipe.delete();
        for (int i = 0; i < SS; i++) pipe.push_back(1'b0);
    endtask

    task automatic model_step(input logic d);
        logic s;
        exp_t e;
        s = pipe.pop_front();
        pipe.push_back(d);
        e = '0;
        if (s != m_q) begin
            m_run++;
            if (m_run == SC) begin
                m_q    = s;
                e.rise = s;
                e.fall = !s;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        e.q    = m_q;
        e.busy = (m_run != 0);
        sb.push_back(e);
    endtask

    // One clock: model the edge with the current din, then drive the next value
    task automatic cycle(input logic v);
        @(posedge Clk);
        model_step(din);
        #1 din = v;
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_q", q, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    // Monitor: compare each edge's outputs against the queued expectation
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("q", q, mon_e.q);
            chk("rise", rise, mon_e.rise);
            chk("fall", fall, mon_e.fall);
            chk("busy", busy, mon_e.busy);
            if (rise && first_rise == 0) first_rise = $time;
        end
    end

    initial begin
        logic cur;
        int   run_left;
        bit   did_mid;
        bit   did_high;
        model_reset();
        din = 1'b0;
        rst = 1'b0;
        #1;
        chk("init_q", q, 1'b0);
        chk("init_busy", busy, 1'b0);
        #1 rst = 1'b1;

        // Clean rise: din goes high before the 15 ns edge, q expected at the 125 ns edge
        cycle(1'b1);
        repeat (19) cycle(1'b1);
        checks++;
        if (first_rise != 130) begin
            errors++;
            $display("FAIL rise_time: got %0t expected 130", first_rise);
        end
        // Clean fall
        repeat (20) cycle(1'b0);
        // Short bounce rejected
        repeat (3) cycle(1'b1);
        repeat (15) cycle(1'b0);
        // Bounce then settle high
        cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b1); cycle(1'b0);
        repeat (20) cycle(1'b1);
        // Toggle every cycle while q is high
        for (int i = 0; i < 24; i++) cycle(i[0]);
        // Reset while q is high, then requalify
        repeat (15) cycle(1'b1);
        reset_pulse();
        repeat (20) cycle(1'b1);
        // Boundary: exactly SC-1 then exactly SC samples low
        repeat (SC - 1) cycle(1'b0);
        repeat (15) cycle(1'b1);
        repeat (SC) cycle(1'b0);
        repeat (5) cycle(1'b1);
        repeat (15) cycle(1'b0);

        // Randomized runs with occasional resets
        cur = 1'b0;
        run_left = 0;
        did_mid = 1'b0;
        did_high = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (run_left == 0) begin
                cur = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 16));
            end
            run_left--;
            cycle(cur);
            if ((!did_mid && m_run > 3) || (!did_high && n > 1500 && m_q)
                || $urandom_range(0, 399) == 0) begin
                if (m_run > 3) did_mid = 1'b1;
                if (m_q) did_high = 1'b1;
                reset_pulse();
            end
        end
        repeat (3) cycle(din);
        @(posedge Clk);
        #6;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
